// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU fetch path: fetch-arbiter FSM states and
// the default program-memory address/data widths used by fetcher and memory.
package gpu_pkg;

    localparam int GPU_ADDR_BITS = 8;
    localparam int GPU_DATA_BITS = 16;

    typedef enum logic [1:0] {
        FETCH_IDLE     = 2'd0,
        FETCH_FETCHING = 2'd1,
        FETCH_RELAYING = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: returns the first set request bit found
// searching upward from ptr, wrapping modulo N.
module rr_picker #(
    parameter int N        = 2,
    parameter int IDX_BITS = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]        req,
    input  logic [IDX_BITS-1:0] ptr,
    output logic                grant_valid,
    output logic [IDX_BITS-1:0] grant_idx
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the loop infers a latch.
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N; k++) begin
            logic [IDX_BITS-1:0] cand;
            cand = IDX_BITS'((int'(ptr) + k) % N);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/program_fetch_arbiter.sv
// Shares one program-memory read channel among several core fetchers:
// round-robin grant, single outstanding read, and same-address coalescing.
module program_fetch_arbiter
    import gpu_pkg::*;
#(
    parameter int NUM_REQUESTERS = 2,
    parameter int ADDR_BITS      = GPU_ADDR_BITS,
    parameter int DATA_BITS      = GPU_DATA_BITS
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_REQUESTERS-1:0]                consumer_read_valid,
    input  logic [NUM_REQUESTERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_REQUESTERS-1:0]                consumer_read_ready,
    output logic [NUM_REQUESTERS-1:0][DATA_BITS-1:0] consumer_read_data,
    output logic                                     mem_read_valid,
    output logic [ADDR_BITS-1:0]                     mem_read_address,
    input  logic                                     mem_read_ready,
    input  logic [DATA_BITS-1:0]                     mem_read_data
);

    localparam int IDX_BITS = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

    fetch_state_e                             state_q, state_d;
    logic [IDX_BITS-1:0]                      rr_ptr_q, rr_ptr_d;
    logic [IDX_BITS-1:0]                      winner_q, winner_d;
    logic [NUM_REQUESTERS-1:0]                served_mask_q, served_mask_d;
    logic [NUM_REQUESTERS-1:0]                ready_q, ready_d;
    logic [NUM_REQUESTERS-1:0][DATA_BITS-1:0] data_q, data_d;
    logic                                     mem_valid_q, mem_valid_d;
    logic [ADDR_BITS-1:0]                     mem_addr_q, mem_addr_d;

    logic [NUM_REQUESTERS-1:0] pending;
    logic                      grant_valid;
    logic [IDX_BITS-1:0]       grant_idx;

    // A requester still holding its ready from the last response is not eligible.
    assign pending = consumer_read_valid & ~ready_q;

    rr_picker #(
        .N        (NUM_REQUESTERS),
        .IDX_BITS (IDX_BITS)
    ) u_rr_picker (
        .req         (pending),
        .ptr         (rr_ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        winner_d      = winner_q;
        served_mask_d = served_mask_q;
        ready_d       = ready_q;
        data_d        = data_q;
        mem_valid_d   = mem_valid_q;
        mem_addr_d    = mem_addr_q;

        case (state_q)
            FETCH_IDLE: begin
                if (grant_valid) begin
                    winner_d    = grant_idx;
                    mem_addr_d  = consumer_read_address[grant_idx];
                    mem_valid_d = 1'b1;
                    state_d     = FETCH_FETCHING;
                end
            end

            FETCH_FETCHING: begin
                if (mem_read_ready) begin
                    mem_valid_d   = 1'b0;
                    served_mask_d = '0;
                    // The winner matches its own address, so an abandoned winner simply drops out.
                    for (int i = 0; i < NUM_REQUESTERS; i++) begin
                        if (consumer_read_valid[i] && consumer_read_address[i] == mem_addr_q) begin
                            served_mask_d[i] = 1'b1;
                            ready_d[i]       = 1'b1;
                            data_d[i]        = mem_read_data;
                        end
                    end
                    rr_ptr_d = (winner_q == IDX_BITS'(NUM_REQUESTERS - 1)) ? '0
                                                                           : winner_q + IDX_BITS'(1);
                    state_d  = FETCH_RELAYING;
                end
            end

            FETCH_RELAYING: begin
                for (int i = 0; i < NUM_REQUESTERS; i++) begin
                    if (served_mask_q[i] && !consumer_read_valid[i]) begin
                        served_mask_d[i] = 1'b0;
                        ready_d[i]       = 1'b0;
                    end
                end
                if (served_mask_d == '0) begin
                    state_d = FETCH_IDLE;
                end
            end

            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    // NOTE: the response data registers are reset along with control so consumers never see stale words after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH_IDLE;
            rr_ptr_q      <= '0;
            winner_q      <= '0;
            served_mask_q <= '0;
            ready_q       <= '0;
            data_q        <= '0;
            mem_valid_q   <= 1'b0;
            mem_addr_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            winner_q      <= winner_d;
            served_mask_q <= served_mask_d;
            ready_q       <= ready_d;
            data_q        <= data_d;
            mem_valid_q   <= mem_valid_d;
            mem_addr_q    <= mem_addr_d;
        end
    end

    assign consumer_read_ready = ready_q;
    assign consumer_read_data  = data_q;
    assign mem_read_valid      = mem_valid_q;
    assign mem_read_address    = mem_addr_q;

endmodule

// File: tb/tb_program_fetch_arbiter.sv
// Directed self-checking bench for program_fetch_arbiter with two requesters.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_program_fetch_arbiter;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       consumer_read_valid;
    logic [1:0][7:0]  consumer_read_address;
    logic [1:0]       consumer_read_ready;
    logic [1:0][15:0] consumer_read_data;
    logic             mem_read_valid;
    logic [7:0]       mem_read_address;
    logic             mem_read_ready;
    logic [15:0]      mem_read_data;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic mem_valid_prev = 1'b0;

    program_fetch_arbiter #(
        .NUM_REQUESTERS (2),
        .ADDR_BITS      (8),
        .DATA_BITS      (16)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .consumer_read_valid   (consumer_read_valid),
        .consumer_read_address (consumer_read_address),
        .consumer_read_ready   (consumer_read_ready),
        .consumer_read_data    (consumer_read_data),
        .mem_read_valid        (mem_read_valid),
        .mem_read_address      (mem_read_address),
        .mem_read_ready        (mem_read_ready),
        .mem_read_data         (mem_read_data)
    );

    always #5 clk = ~clk;

    // Counts distinct memory request pulses (rising edges of mem_read_valid).
    always @(posedge clk) begin
        if (mem_read_valid && !mem_valid_prev) pulses++;
        mem_valid_prev <= mem_read_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Waits (bounded) for a memory request, delays lat cycles, then returns one response word.
    task automatic serve(input string tag, input int lat, input logic [15:0] word,
                         output logic [7:0] addr_seen, output int waited);
        waited = 0;
        while (!mem_read_valid && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, "_mem_valid"}, 32'(mem_read_valid), 32'd1);
        addr_seen = mem_read_address;
        repeat (lat) tick();
        check({tag, "_ready_before_resp"}, 32'(consumer_read_ready), 32'd0);
        mem_read_ready = 1'b1;
        mem_read_data  = word;
        tick();
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
    endtask

    initial begin
        logic [7:0] addr_seen;
        int         waited;
        int         pulses_before;
        logic [7:0] exp_addr;
        int         exp_idx;

        reset                 = 1'b1;
        consumer_read_valid   = '0;
        consumer_read_address = '0;
        mem_read_ready        = 1'b0;
        mem_read_data         = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_mem_valid", 32'(mem_read_valid), 32'd0);
        check("rst_mem_addr", 32'(mem_read_address), 32'd0);
        check("rst_ready", 32'(consumer_read_ready), 32'd0);
        check("rst_data", 32'(consumer_read_data), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'd0);

        // 1: single request from consumer 0
        consumer_read_valid      = 2'b01;
        consumer_read_address[0] = 8'h05;
        serve("t1", 2, 16'hA1B2, addr_seen, waited);
        check("t1_req_latency", 32'(waited), 32'd1);
        check("t1_mem_addr", 32'(addr_seen), 32'h05);
        check("t1_ready", 32'(consumer_read_ready), 32'b01);
        check("t1_data0", 32'(consumer_read_data[0]), 32'hA1B2);
        check("t1_mem_valid_off", 32'(mem_read_valid), 32'd0);
        check("t1_state_relay", 32'(dut.state_q), 32'd2);
        consumer_read_valid = 2'b00;
        tick();
        check("t1_ready_clear", 32'(consumer_read_ready), 32'd0);
        check("t1_state_idle", 32'(dut.state_q), 32'd0);
        check("t1_rr_ptr", 32'(dut.rr_ptr_q), 32'd1);

        // 2: round-robin with both consumers continuously requesting
        do_reset();
        consumer_read_address[0] = 8'h10;
        consumer_read_address[1] = 8'h20;
        consumer_read_valid      = 2'b11;
        for (int g = 0; g < 4; g++) begin
            exp_idx  = g % 2;
            exp_addr = (exp_idx == 0) ? 8'h10 : 8'h20;
            serve("t2", 1, 16'h1000 + 16'(g), addr_seen, waited);
            check("t2_grant_addr", 32'(addr_seen), 32'(exp_addr));
            check("t2_ready", 32'(consumer_read_ready), 32'(2'b01 << exp_idx));
            check("t2_data", 32'(consumer_read_data[exp_idx]), 32'h1000 + 32'(g));
            consumer_read_valid[exp_idx] = 1'b0;
            tick();
            check("t2_ready_clear", 32'(consumer_read_ready), 32'd0);
            consumer_read_valid[exp_idx] = 1'b1;
        end
        consumer_read_valid = 2'b00;
        tick();
        tick();

        // 3: coalesced fetch, then 4: staggered release
        do_reset();
        pulses_before            = pulses;
        consumer_read_address[0] = 8'h07;
        consumer_read_address[1] = 8'h07;
        consumer_read_valid      = 2'b11;
        serve("t3", 2, 16'h5A5A, addr_seen, waited);
        check("t3_mem_addr", 32'(addr_seen), 32'h07);
        check("t3_ready_both", 32'(consumer_read_ready), 32'b11);
        check("t3_data0", 32'(consumer_read_data[0]), 32'h5A5A);
        check("t3_data1", 32'(consumer_read_data[1]), 32'h5A5A);
        tick();
        consumer_read_valid[0] = 1'b0;
        tick();
        check("t4_ready0_first", 32'(consumer_read_ready), 32'b10);
        check("t4_state_relay", 32'(dut.state_q), 32'd2);
        tick();
        tick();
        consumer_read_valid[1] = 1'b0;
        check("t4_ready1_held", 32'(consumer_read_ready), 32'b10);
        check("t4_state_still_relay", 32'(dut.state_q), 32'd2);
        tick();
        check("t4_ready_clear", 32'(consumer_read_ready), 32'd0);
        check("t4_state_idle", 32'(dut.state_q), 32'd0);
        check("t3_one_pulse", 32'(pulses - pulses_before), 32'd1);
        check("t3_mem_valid_off", 32'(mem_read_valid), 32'd0);

        // 5: reset while a memory read is outstanding
        consumer_read_address[0] = 8'h42;
        consumer_read_valid      = 2'b01;
        tick();
        check("t5_mem_valid", 32'(mem_read_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset               = 1'b0;
        consumer_read_valid = 2'b00;
        check("t5_mem_valid_rst", 32'(mem_read_valid), 32'd0);
        check("t5_mem_addr_rst", 32'(mem_read_address), 32'd0);
        check("t5_ready_rst", 32'(consumer_read_ready), 32'd0);
        check("t5_data_rst", 32'(consumer_read_data), 32'd0);
        check("t5_state_rst", 32'(dut.state_q), 32'd0);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hDEAD;
        tick();
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        check("t5_late_resp_ready", 32'(consumer_read_ready), 32'd0);
        check("t5_late_resp_data", 32'(consumer_read_data), 32'd0);
        check("t5_late_resp_state", 32'(dut.state_q), 32'd0);

        // 6: winner abandons its request before the memory answers
        consumer_read_address[1] = 8'h30;
        consumer_read_valid      = 2'b10;
        tick();
        check("t6_mem_valid", 32'(mem_read_valid), 32'd1);
        check("t6_mem_addr", 32'(mem_read_address), 32'h30);
        consumer_read_valid = 2'b00;
        tick();
        check("t6_mem_valid_held", 32'(mem_read_valid), 32'd1);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hBEEF;
        tick();
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        check("t6_mem_valid_off", 32'(mem_read_valid), 32'd0);
        check("t6_no_ready", 32'(consumer_read_ready), 32'd0);
        tick();
        check("t6_state_idle", 32'(dut.state_q), 32'd0);
        check("t6_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
        check("t6_no_ready_after", 32'(consumer_read_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
